// File: rtl/pwm_multi_channel_pkg.sv
// Shared sizing helpers for the multi-channel PWM block.
package pwm_pkg;

  // Last counter value of a period; the period is 2**w-1 ticks long.
  function automatic int unsigned cnt_max(input int unsigned w);
    return (32'd1 << w) - 32'd2;
  endfunction

  // Duty value that keeps an output permanently high.
  function automatic int unsigned duty_full(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  // Width of the channel select field; never zero, even for one channel.
  function automatic int unsigned chan_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pwm_multi_channel_if.sv
// Control and output bundle of pwm_multi_channel; master drives config/writes, slave is the PWM.
interface pwm_multi_channel_if #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8,
  parameter int PRESC_W  = 4
) ();
  import pwm_pkg::*;

  logic                          enable;
  logic [PRESC_W-1:0]            prescale;
  logic                          wr_en;
  logic [chan_w(CHANNELS)-1:0]   wr_chan;
  logic [CNT_W-1:0]              wr_duty;
  logic [CHANNELS-1:0]           pwm_out;
  logic                          period_strb;

  modport master (
    output enable, prescale, wr_en, wr_chan, wr_duty,
    input  pwm_out, period_strb
  );

  modport slave (
    input  enable, prescale, wr_en, wr_chan, wr_duty,
    output pwm_out, period_strb
  );
endinterface

// File: rtl/pwm_multi_channel_channel.sv
// One PWM channel: shadow/active duty and registered compare output (1 clock latency).
// PWM_RAMP_EN: active steps by one toward the shadow per period instead of jumping.
module pwm_channel #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable_i,
  input  logic             boundary_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             wr_hit_i,
  input  logic [CNT_W-1:0] wr_duty_i,
  output logic             pwm_o
);
  typedef logic [CNT_W-1:0] duty_t;

  duty_t shadow_q, shadow_d;
  duty_t active_q, active_d;
  logic  pwm_q, pwm_d;

  // shadow_d already carries a coincident write, which gives the boundary bypass for free.
  always_comb begin
    shadow_d = wr_hit_i ? wr_duty_i : shadow_q;
    active_d = active_q;
`ifdef PWM_RAMP_EN
    if (!enable_i) begin
      active_d = '0;
    end else if (boundary_i) begin
      if (active_q < shadow_d)      active_d = active_q + 1'b1;
      else if (active_q > shadow_d) active_d = active_q - 1'b1;
    end
`else
    if (!enable_i || boundary_i) begin
      active_d = shadow_d;
    end
`endif
    pwm_d = enable_i && (cnt_i < active_q);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shadow_q <= '0;
      active_q <= '0;
      pwm_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;
endmodule

// File: rtl/pwm_multi_channel.sv
// N-channel PWM: shared prescaler and period counter, per-channel duty applied at period boundaries.
// Outputs registered (1 clock); no backpressure, writes always accepted. Optional PWM_RAMP_EN soft-start.
module pwm_multi_channel
  import pwm_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8,
  parameter int PRESC_W  = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  pwm_multi_channel_if.slave   bus
);
  typedef logic [CNT_W-1:0] duty_t;
  localparam duty_t MAX = duty_t'(cnt_max(CNT_W));

  logic [PRESC_W-1:0]  presc_cnt_q, presc_cnt_d;
  logic [PRESC_W-1:0]  presc_lat_q, presc_lat_d;
  duty_t               cnt_q, cnt_d;
  logic                strb_q, strb_d;
  logic                tick, boundary;
  logic [CHANNELS-1:0] wr_hit;
  logic [CHANNELS-1:0] pwm_vec;

  always_comb begin
    tick        = bus.enable && (presc_cnt_q == presc_lat_q);
    boundary    = tick && (cnt_q == MAX);
    presc_cnt_d = presc_cnt_q;
    presc_lat_d = presc_lat_q;
    cnt_d       = cnt_q;
    strb_d      = 1'b0;
    if (!bus.enable) begin
      presc_cnt_d = '0;
      presc_lat_d = bus.prescale;
      cnt_d       = '0;
    end else begin
      presc_cnt_d = tick ? '0 : presc_cnt_q + 1'b1;
      if (boundary) presc_lat_d = bus.prescale;
      if (tick)     cnt_d = (cnt_q == MAX) ? '0 : cnt_q + 1'b1;
      strb_d      = boundary;
    end
  end

  // Codes at or above CHANNELS match no channel and are dropped.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      wr_hit[i] = bus.wr_en && (int'(bus.wr_chan) == i);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc_cnt_q <= '0;
      presc_lat_q <= '0;
      cnt_q       <= '0;
      strb_q      <= 1'b0;
    end else begin
      presc_cnt_q <= presc_cnt_d;
      presc_lat_q <= presc_lat_d;
      cnt_q       <= cnt_d;
      strb_q      <= strb_d;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pwm_channel #(.CNT_W(CNT_W)) u_ch (
      .clock      (clock),
      .reset      (reset),
      .enable_i   (bus.enable),
      .boundary_i (boundary),
      .cnt_i      (cnt_q),
      .wr_hit_i   (wr_hit[i]),
      .wr_duty_i  (bus.wr_duty),
      .pwm_o      (pwm_vec[i])
    );
  end

  assign bus.pwm_out     = pwm_vec;
  assign bus.period_strb = strb_q;
endmodule

// File: tb/tb_pwm_multi_channel.sv
// Directed bench for pwm_multi_channel (3 channels so wr_chan has an unused code); ramp steps under PWM_RAMP_EN.
module tb_pwm_multi_channel;
  import pwm_pkg::*;

  localparam int CH   = 3;
  localparam int CW   = 4;
  localparam int PW   = 4;
  localparam int FULL = duty_full(CW);

  logic clock = 1'b0;
  logic reset;
  int   n_run  = 0;
  int   n_fail = 0;
  int   m_len;
  int   m_hi[CH];

  pwm_multi_channel_if #(.CHANNELS(CH), .CNT_W(CW), .PRESC_W(PW)) bus ();

  pwm_multi_channel #(.CHANNELS(CH), .CNT_W(CW), .PRESC_W(PW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    n_run++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive_wr(input int ch, input int d);
    bus.wr_en   = 1'b1;
    bus.wr_chan = ch[1:0];
    bus.wr_duty = d[3:0];
  endtask

  task automatic write(input int ch, input int d);
    @(negedge clock);
    drive_wr(ch, d);
    @(negedge clock);
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_strb();
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (bus.period_strb) break;
    end
    check("wait_strb", int'(bus.period_strb), 1);
  endtask

  // Samples one period up to and including the next strobe; optional write(s) at sample wr_at (and wr_at+1).
  task automatic measure(input int wr_at, input int ch, input int d, input int d2);
    m_len = 0;
    for (int i = 0; i < CH; i++) m_hi[i] = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clock);
      bus.wr_en = 1'b0;
      m_len++;
      for (int i = 0; i < CH; i++) m_hi[i] += int'(bus.pwm_out[i]);
      if (bus.period_strb) break;
      if (m_len == wr_at) drive_wr(ch, d);
      else if (m_len == wr_at + 1 && d2 >= 0) drive_wr(ch, d2);
    end
  endtask

  task automatic check_period(input string tag, input int len, input int h0, input int h1, input int h2);
    check({tag, "_len"}, m_len, len);
    check({tag, "_ch0"}, m_hi[0], h0);
    check({tag, "_ch1"}, m_hi[1], h1);
    check({tag, "_ch2"}, m_hi[2], h2);
  endtask

  initial begin
    reset        = 1'b1;
    bus.enable   = 1'b0;
    bus.prescale = '0;
    bus.wr_en    = 1'b0;
    bus.wr_chan  = '0;
    bus.wr_duty  = '0;
    repeat (2) @(negedge clock);
    check("rst_pwm", int'(bus.pwm_out), 0);
    check("rst_strb", int'(bus.period_strb), 0);
    reset = 1'b0;

`ifdef PWM_RAMP_EN
    begin
      int exp_up[6] = '{0, 1, 2, 3, 4, 4};
      int exp_dn[4] = '{4, 3, 2, 1};
      write(0, 4);
      bus.enable = 1'b1;
      for (int p = 0; p < 6; p++) begin
        measure(-1, 0, 0, -1);
        check_period($sformatf("ramp_up%0d", p), FULL, exp_up[p], 0, 0);
      end
      measure(2, 0, 1, -1);
      check_period("ramp_dn0", FULL, exp_dn[0], 0, 0);
      for (int p = 1; p < 4; p++) begin
        measure(-1, 0, 0, -1);
        check_period($sformatf("ramp_dn%0d", p), FULL, exp_dn[p], 0, 0);
      end
      measure(-1, 0, 0, -1);
      check_period("ramp_hold", FULL, 1, 0, 0);
    end
`else
    // Basic duty and full-scale, started from a disabled state.
    write(0, 5);
    write(1, FULL);
    write(2, 0);
    check("off_pwm", int'(bus.pwm_out), 0);
    bus.enable = 1'b1;
    measure(-1, 0, 0, -1);  check_period("first", 15, 5, 15, 0);
    measure(-1, 0, 0, -1);  check_period("p2",    15, 5, 15, 0);
    measure(-1, 0, 0, -1);  check_period("p3",    15, 5, 15, 0);

    // Mid-period writes wait for the boundary; a boundary write takes effect at once.
    measure(2, 0, 8, -1);   check_period("wr8",   15, 5, 15, 0);
    measure(-1, 0, 0, -1);  check_period("run8",  15, 8, 15, 0);
    measure(3, 0, 3, -1);   check_period("wr3",   15, 8, 15, 0);
    measure(-1, 0, 0, -1);  check_period("run3",  15, 3, 15, 0);
    measure(2, 0, 8, -1);   check_period("wr8b",  15, 3, 15, 0);
    measure(14, 0, 3, -1);  check_period("bwr3",  15, 8, 15, 0);
    measure(-1, 0, 0, -1);  check_period("byp3",  15, 3, 15, 0);
    measure(4, 0, 9, 6);    check_period("ww",    15, 3, 15, 0);
    measure(-1, 0, 0, -1);  check_period("last",  15, 6, 15, 0);

    // Out-of-range channel code changes nothing.
    measure(5, 3, 9, -1);   check_period("badch", 15, 6, 15, 0);
    measure(-1, 0, 0, -1);  check_period("badch2", 15, 6, 15, 0);

    // Prescale is picked up only at a boundary.
    measure(2, 0, 4, -1);   check_period("d4",    15, 6, 15, 0);
    bus.prescale = 4'd2;
    measure(-1, 0, 0, -1);  check_period("ps_old", 15, 4, 15, 0);
    measure(-1, 0, 0, -1);  check_period("ps2",   45, 12, 45, 0);
    bus.prescale = 4'd1;
    measure(-1, 0, 0, -1);  check_period("ps2b",  45, 12, 45, 0);
    measure(-1, 0, 0, -1);  check_period("ps1",   30, 8, 30, 0);
    bus.prescale = 4'd0;
    measure(-1, 0, 0, -1);  check_period("ps1b",  30, 8, 30, 0);
    measure(-1, 0, 0, -1);  check_period("ps0",   15, 4, 15, 0);

    // Asynchronous reset in the high phase.
    repeat (3) @(negedge clock);
    check("pre_rst_pwm", int'(bus.pwm_out), 3);
    reset = 1'b1;
    #1;
    check("async_pwm", int'(bus.pwm_out), 0);
    check("async_strb", int'(bus.period_strb), 0);
    bus.enable = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_pwm", int'(bus.pwm_out), 0);
    write(0, 6);
    write(1, 2);
    bus.enable = 1'b1;
    measure(-1, 0, 0, -1);  check_period("rst_run", 15, 6, 2, 0);

    // Disable mid-period, write while off, restart from cnt 0.
    repeat (4) @(negedge clock);
    bus.enable = 1'b0;
    write(2, 7);
    check("dis_pwm", int'(bus.pwm_out), 0);
    check("dis_strb", int'(bus.period_strb), 0);
    bus.enable = 1'b1;
    measure(-1, 0, 0, -1);  check_period("restart", 15, 6, 2, 7);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
